// File: rtl/y_sequencer_pkg.sv
// Shared definitions for the Y register sequencer: Y select codes, command
// opcodes and the sequencer state enumeration.
package y_sequencer_pkg;

  localparam int unsigned Y_DATA_W = 4;
  localparam int unsigned Y_CNT_W  = 2;
  localparam int unsigned SEL_W    = 3;
  localparam int unsigned OP_W     = 2;

  // Y register select codes
  localparam logic [SEL_W-1:0] SEL_LIMPAR    = 3'b000;
  localparam logic [SEL_W-1:0] SEL_CARREGAR  = 3'b001;
  localparam logic [SEL_W-1:0] SEL_MANTER    = 3'b010;
  localparam logic [SEL_W-1:0] SEL_SESQUERDA = 3'b011;
  localparam logic [SEL_W-1:0] SEL_SDIREITA  = 3'b100;

  // Command opcodes
  localparam logic [OP_W-1:0] OP_CLEAR = 2'b00;
  localparam logic [OP_W-1:0] OP_LOAD  = 2'b01;
  localparam logic [OP_W-1:0] OP_SHL   = 2'b10;
  localparam logic [OP_W-1:0] OP_SHR   = 2'b11;

  typedef enum logic [1:0] {
    ST_INIT  = 2'b00,
    ST_IDLE  = 2'b01,
    ST_ISSUE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/y_sequencer.sv
// Command sequencer for the 4-bit Y register: turns clear/load/shift commands
// into Y select cycles and keeps a shadow copy of Y in lockstep.
module y_sequencer
  import y_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = Y_DATA_W,
  parameter int unsigned CNT_W  = Y_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic [SEL_W-1:0]  y_sel,
  output logic [DATA_W-1:0] y_entrada,
  output logic [DATA_W-1:0] y_shadow,
  output logic              busy,
  output logic              done
);

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic [SEL_W-1:0]    sel_nx;
  logic [DATA_W-1:0]   entrada_nx;
  logic [DATA_W-1:0]   shadow_nx;
  logic                ready_nx;
  logic                busy_nx;
  logic                done_nx;
  logic                accept;
  logic [CNT_W-1:0]    shamt;

  assign accept = cmd_valid & cmd_ready;
  assign shamt  = cmd_data[CNT_W-1:0];

  // State and registered outputs; reset clears Y via LIMPAR on every reset edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INIT;
      cnt       <= '0;
      y_sel     <= SEL_LIMPAR;
      y_entrada <= '0;
      y_shadow  <= '0;
      cmd_ready <= 1'b0;
      busy      <= 1'b1;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      y_sel     <= sel_nx;
      y_entrada <= entrada_nx;
      y_shadow  <= shadow_nx;
      cmd_ready <= ready_nx;
      busy      <= busy_nx;
      done      <= done_nx;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    sel_nx     = y_sel;
    entrada_nx = y_entrada;
    shadow_nx  = y_shadow;
    ready_nx   = cmd_ready;
    done_nx    = 1'b0;

    unique case (state)
      ST_INIT: begin
        state_nx = ST_IDLE;
        sel_nx   = SEL_MANTER;
        ready_nx = 1'b1;
      end

      ST_IDLE: begin
        sel_nx   = SEL_MANTER;
        ready_nx = 1'b1;
        if (accept) begin
          ready_nx = 1'b0;
          unique case (cmd_op)
            OP_CLEAR: begin
              state_nx = ST_ISSUE;
              sel_nx   = SEL_LIMPAR;
              cnt_nx   = '0;
            end
            OP_LOAD: begin
              state_nx   = ST_ISSUE;
              sel_nx     = SEL_CARREGAR;
              entrada_nx = cmd_data;
              cnt_nx     = '0;
            end
            default: begin
              // Zero-length shift completes without touching Y
              if (shamt == '0) begin
                state_nx = ST_DONE;
                done_nx  = 1'b1;
              end else begin
                state_nx = ST_ISSUE;
                sel_nx   = (cmd_op == OP_SHL) ? SEL_SESQUERDA : SEL_SDIREITA;
                cnt_nx   = CNT_W'(shamt - CNT_W'(1));
              end
            end
          endcase
        end
      end

      ST_ISSUE: begin
        // Shadow follows the same select code Y sees on this edge
        unique case (y_sel)
          SEL_LIMPAR:    shadow_nx = '0;
          SEL_CARREGAR:  shadow_nx = y_entrada;
          SEL_SESQUERDA: shadow_nx = {y_shadow[DATA_W-2:0], 1'b0};
          SEL_SDIREITA:  shadow_nx = {1'b0, y_shadow[DATA_W-1:1]};
          default:       shadow_nx = y_shadow;
        endcase
        if (cnt == '0) begin
          state_nx = ST_DONE;
          sel_nx   = SEL_MANTER;
          done_nx  = 1'b1;
        end else begin
          cnt_nx = CNT_W'(cnt - CNT_W'(1));
        end
      end

      ST_DONE: begin
        state_nx = ST_IDLE;
        ready_nx = 1'b1;
      end

      default: begin
        state_nx = ST_INIT;
        sel_nx   = SEL_LIMPAR;
        ready_nx = 1'b0;
      end
    endcase

    busy_nx = (state_nx != ST_IDLE);
  end

endmodule
